// File: rtl/pixel_writer.sv
// Pixel writer: clips incoming pixel coordinates against the raster, turns
// in-bounds pixels into {address,color} entries, queues them and drains the
// queue to memory through a simple request/accept write port.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no write presented; waits for the queue to become non-empty
//   S_WRITE | queue head driven on wr_addr/wr_data with wr_ena high
module pixel_writer #(
  parameter int BITS_RES    = 12,
  parameter int ADDR_W      = 20,
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 1024,
  parameter int FIFO_DEPTH  = 8,
  parameter int PAUSE_LEVEL = FIFO_DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       pixel_data_rdy,
  input  logic signed [BITS_RES-1:0] X_coord,
  input  logic signed [BITS_RES-1:0] Y_coord,
  input  logic [7:0]                 color,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       ena_pause,
  output logic                       wr_ena,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       busy,
  output logic [15:0]                pix_written,
  output logic [15:0]                pix_clipped,
  output logic                       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 8;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                ena_pause_q;
  logic [15:0]         pix_written_q, pix_clipped_q;
  logic                overflow_q;

  logic signed [31:0]  x_s, y_s;
  logic [31:0]         lin;
  logic                accept, in_bnd, full, push, drop, clip;
  logic                pop_req, pop_fire;
  logic [EW-1:0]       entry;

  // Coordinates are sign-extended so the bounds test is a plain signed compare.
  assign x_s    = 32'(X_coord);
  assign y_s    = 32'(Y_coord);
  assign in_bnd = (x_s >= 0) && (y_s >= 0) && (x_s < SCREEN_W) && (y_s < SCREEN_H);
  assign lin    = 32'(y_s * SCREEN_W + x_s);
  assign entry  = {base_addr + ADDR_W'(lin), color};

  assign accept   = enable && pixel_data_rdy;
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign pop_fire = enable && pop_req;
  // A push into a full queue still succeeds when the head leaves in the same cycle.
  assign push     = accept && in_bnd && (!full || pop_fire);
  assign drop     = accept && in_bnd && full && !pop_fire;
  assign clip     = accept && !in_bnd;
  assign rd_nxt   = rd_ptr_q + 1'b1;

  // Occupancy update from push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  // Queue pointers, occupancy, pause flag and status counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      ena_pause_q   <= 1'b0;
      pix_written_q <= '0;
      pix_clipped_q <= '0;
      overflow_q    <= 1'b0;
    end else if (enable) begin
      if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_fire) rd_ptr_q <= rd_nxt;
      cnt_q       <= cnt_d;
      ena_pause_q <= (cnt_q >= CW'(PAUSE_LEVEL));
      if (pop_fire && (pix_written_q != 16'hFFFF)) pix_written_q <= pix_written_q + 16'd1;
      if (clip && (pix_clipped_q != 16'hFFFF))     pix_clipped_q <= pix_clipped_q + 16'd1;
      if (drop)     overflow_q <= 1'b1;
    end
  end

  // Output-stage next state: present head, pop on accept, chain to next entry.
  always_comb begin
    state_d   = state_q;
    wr_ena_d  = wr_ena_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pop_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          state_d                = S_WRITE;
          wr_ena_d               = 1'b1;
          {wr_addr_d, wr_data_d} = mem_q[rd_ptr_q];
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          pop_req = 1'b1;
          // Only chain when an entry behind the head already exists; a pixel
          // pushed in this same cycle is picked up from IDLE next cycle.
          if (cnt_q > CW'(1)) begin
            {wr_addr_d, wr_data_d} = mem_q[rd_nxt];
          end else begin
            state_d  = S_IDLE;
            wr_ena_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        wr_ena_d = 1'b0;
      end
    endcase
  end

  // Output-stage registers; held while enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (enable) begin
      state_q   <= state_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign ena_pause   = ena_pause_q;
  assign wr_ena      = wr_ena_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign pix_written = pix_written_q;
  assign pix_clipped = pix_clipped_q;
  assign overflow    = overflow_q;
  assign busy        = (cnt_q != '0) || wr_ena_q;

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameters (name, default, meaning): BITS_RES, 12, signed coordinate width.
REQ-002 SHALL have parameter ADDR_W, 20, memory byte-address width.
REQ-003 SHALL have parameter SCREEN_W, 1024, raster width in pixels (power of 2).
REQ-004 SHALL have parameter SCREEN_H, 1024, raster height in pixels.
REQ-005 SHALL have parameter FIFO_DEPTH, 8, pixel queue depth (power of 2, >=4).
REQ-006 SHALL have parameter PAUSE_LEVEL, FIFO_DEPTH-2, occupancy at which ena_pause asserts.
REQ-007 SHALL have ports (name, direction, width, meaning): clk, in, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-009 SHALL have port enable, in, 1, logic enable; low freezes all state.
REQ-010 SHALL have port pixel_data_rdy, in, 1, X_coord/Y_coord valid this cycle.
REQ-011 SHALL have ports X_coord and Y_coord, in, BITS_RES signed each, pixel coordinates from a geometry generator.
REQ-012 SHALL have port color, in, 8, pixel color sampled with pixel_data_rdy.
REQ-013 SHALL have port base_addr, in, ADDR_W, raster base address; sampled at push.
REQ-014 SHALL have port ena_pause, out, 1, back-pressure to the generator.
REQ-015 SHALL have ports wr_ena, out, 1, and wr_ready, in, 1, memory write request/accept.
REQ-016 SHALL have ports wr_addr, out, ADDR_W, and wr_data, out, 8, memory write address and data.
REQ-017 SHALL have port busy, out, 1, queue non-empty or write outstanding.
REQ-018 SHALL have ports pix_written, out, 16, and pix_clipped, out, 16, saturating counters.
REQ-019 SHALL have port overflow, out, 1, sticky; set when a pixel is lost.

Function
REQ-020 SHALL accept a pixel when enable && pixel_data_rdy; no pixel is accepted while enable is low.
REQ-021 SHALL clip an accepted pixel when X<0, Y<0, X>=SCREEN_W or Y>=SCREEN_H (signed compare); clipped pixels are not queued, and pix_clipped increments.
REQ-022 SHALL compute the address for an in-bounds pixel at acceptance: base_addr + Y*SCREEN_W + X, truncated modulo 2^ADDR_W; the {address,color} pair is queued.
REQ-023 SHALL queue in FIFO order with no reordering; occupancy ranges 0..FIFO_DEPTH.
REQ-024 SHALL drop an in-bounds pixel arriving while full with no same-cycle pop, setting overflow.
REQ-025 SHALL accept the push when full with a same-cycle pop; occupancy is unchanged.
REQ-026 SHALL register ena_pause: high the cycle after occupancy >= PAUSE_LEVEL, low the cycle after occupancy < PAUSE_LEVEL.
REQ-027 SHALL implement the output stage FSM IDLE/WRITE: IDLE->WRITE when the queue is non-empty (wr_ena=1 next cycle, head on wr_addr/wr_data); in WRITE, wr_ena && wr_ready pops the entry and increments pix_written; back-to-back writes are allowed when the next entry exists; WRITE->IDLE on pop with an empty queue.
REQ-028 SHALL hold wr_addr/wr_data stable while wr_ena=1 && wr_ready=0.
REQ-029 SHALL deliver a pixel accepted at edge N to wr_ena/wr_addr no earlier than edge N+1 and no later than edge N+2 when the queue was empty and wr_ready=1.
REQ-030 SHALL freeze the FSM, FIFO, counters and outputs while enable is low; a pending wr_ena stays asserted but no pop occurs.
REQ-031 SHALL saturate pix_written and pix_clipped at 16'hFFFF.
REQ-032 SHALL drive busy = (occupancy != 0) || wr_ena, combinationally.

Reset
REQ-033 SHALL asynchronously, on reset low, clear the FIFO, set the FSM to IDLE, and zero wr_ena, wr_addr, wr_data, ena_pause, pix_written, pix_clipped and overflow; a write in flight is abandoned.
REQ-034 SHALL hold all outputs at reset values until the first rising clk after reset goes high.

Verification
REQ-035 SHALL verify a single pixel: base=0, (X,Y)=(5,3), color=8'h7F, wr_ready=1 -> one write, wr_addr=3077, wr_data=8'h7F, pix_written=1.
REQ-036 SHALL verify clipping: pixels (-1,0), (1024,0), (0,1024) and (1023,1023) -> exactly one write at addr 1048575; pix_clipped=3.
REQ-037 SHALL verify back-pressure: wr_ready=0 and 8 consecutive pixels -> ena_pause high after the 6th; a 9th pixel sets overflow; releasing wr_ready -> 8 in-order writes.
REQ-038 SHALL verify a stall: wr_ready toggled every other cycle over 20 pixels -> wr_addr/wr_data stable while stalled, 20 writes in order, no duplicates.
REQ-039 SHALL verify reset mid-stream: reset low with 4 queued -> wr_ena=0 and busy=0 at once, counters 0, no writes after release.
REQ-040 SHALL verify enable low for 10 cycles while full -> no pops or counter change; resume completes with no loss.
